instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The ports SHALL be: clock  in  1  rising-edge clock.
REQ-002 reset  in  1  synchronous, active-low reset.
REQ-003 w_start  in  1  pulse that begins a session and loads w_base_addr_32; w_base_addr_32  in  32  first write address of the session.
REQ-004 w_end  in  1  pulse requesting that the session close once all buffered words are written.
REQ-005 w_in_valid  in  1 / w_in_ready  out  1  field-input handshake; a transfer occurs when both are 1 on a clock edge.
REQ-006 w_fmt_2  in  2  word format: 00 R (SPECIAL), 01 I, 10 J, 11 REGIMM.
REQ-007 w_op_type_6  in  6  funct for R, opcode for I/J, branch code (bits 4:0) for REGIMM.
REQ-008 w_rs_addr_5, w_rt_addr_5, w_rd_addr_5, w_sh_amt_5  in  5 each; w_imm_val_16  in  16; w_target_26  in  26.
REQ-009 w_mem_addr_32  out  32, w_mem_data_32  out  32, w_mem_we  out  1, w_mem_ready  in  1  instruction-memory write port; a write completes when w_mem_we and w_mem_ready are both 1.
REQ-010 w_busy  out  1, w_done  out  1 (one-cycle pulse), w_count_16  out  16 (words written this session), w_err  out  1.

Function
REQ-011 Packing SHALL be: R = {6'h00, rs, rt, rd, shamt, op_type}; I = {op_type, rs, rt, imm}; J = {op_type, target}; REGIMM = {6'h01, rs, op_type[4:0], imm}.
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE; IDLE->RUN on w_start; RUN->DONE when the end flag is latched and the FIFO is empty; DONE->IDLE after one cycle.
REQ-013 In the cycle w_start is accepted, the block SHALL load the address register with w_base_addr_32, clear w_count_16, the end flag and w_err, and SHALL ignore w_start in RUN and DONE.
REQ-014 w_end SHALL be latched only in RUN; w_end in IDLE or DONE SHALL be ignored; w_end in the same cycle as w_start SHALL be ignored.
REQ-015 The packed word SHALL be pushed into a 4-entry FIFO on each accepted transfer; w_in_ready = (state==RUN) & !full & !end_flag.
REQ-016 Latency: a word accepted at edge N SHALL be visible on w_mem_data_32 with w_mem_we=1 at cycle N+1 at the earliest; there is no combinational input-to-output path.
REQ-017 w_mem_we = (state==RUN) & !empty; w_mem_data_32 = FIFO head; data and address SHALL hold stable while w_mem_ready=0.
REQ-018 On each completed write, the address SHALL increment by 4 modulo 2^32, and w_count_16 SHALL increment, saturating at 16'hFFFF.
REQ-019 A simultaneous push and pop SHALL be allowed when not full; a full FIFO SHALL refuse a push even if a pop occurs in the same cycle.
REQ-020 FIFO pointers SHALL wrap modulo 4, and occupancy SHALL be tracked in 0..4.
REQ-021 w_busy = (state != IDLE); w_done = 1 only in DONE.

Reset
REQ-022 While reset=0 at a rising edge: state IDLE, FIFO empty, address 0, w_count_16 0, end flag 0, w_err 0, w_mem_we 0, w_in_ready 0, w_done 0, w_busy 0.
REQ-023 A reset asserted mid-session SHALL discard the FIFO contents with no further memory writes, and SHALL NOT pulse w_done.

Configuration
REQ-024 With ENCODER_CHECK_EN defined, each input SHALL be legality-checked against the following sets:
- I: 04-07, 09-0F, 1C, 20, 23, 24, 28, 2B.
- J: 02, 03.
- REGIMM: 00, 01.
- R: all codes legal.
REQ-025 With ENCODER_CHECK_EN defined, an illegal input SHALL still be accepted, SHALL be written as 32'h00000000, and SHALL set w_err sticky until the next accepted w_start.
REQ-026 Without ENCODER_CHECK_EN, all inputs SHALL be packed unchecked and w_err SHALL be tied to 0.

Structure
REQ-027 Opcode, funct, REGIMM codes and the w_fmt_2 encodings SHALL live in the shared isa_codes package, reused by the decoder.
REQ-028 The FIFO SHALL be a sub-module named instr_fifo (parameter DEPTH=4, WIDTH=32); packing and the FSM SHALL stay in instr_encoder.

Verification
REQ-029 The bench SHALL cover: start base 0x00400000, R op 0x21 rs=1 rt=2 rd=3 -> write 0x00221821 @0x00400000, count=1.
REQ-030 The bench SHALL cover: I op 0x09 rt=8 imm 0x0005 -> 0x24080005; J op 0x02 target 0x0100000 -> 0x08100000; REGIMM rs=4 code 1 imm 0xFFFE -> 0x0481FFFE, at consecutive addresses.
REQ-031 The bench SHALL cover: w_mem_ready=0 with 5 valid inputs -> 4 accepted, w_in_ready=0 from the cycle after the 4th; then ready=1 -> 4 in-order writes, 5th accepted.
REQ-032 The bench SHALL cover: base 0xFFFFFFFC, two words -> addresses 0xFFFFFFFC then 0x00000000.
REQ-033 The bench SHALL cover: w_end with 3 words buffered -> all 3 written, then w_done pulses exactly once, and the next cycle is IDLE.
REQ-034 The bench SHALL cover: with ENCODER_CHECK_EN, I op 0x3F -> write 0x00000000, w_err=1 until the next start; and reset=0 mid-RUN -> no writes afterwards and w_done stays 0.

Source files
------------

// File: rtl/isa_codes_pkg.sv
// Shared ISA code points, word formats, encoder states and field packing.
// Reused by the instruction encoder and the decoder.
package isa_codes;

    typedef enum logic [1:0] {
        FMT_R      = 2'b00,
        FMT_I      = 2'b01,
        FMT_J      = 2'b10,
        FMT_REGIMM = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } enc_state_e;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_OR   = 6'h25;

    localparam logic [4:0] RI_BLTZ = 5'h00;
    localparam logic [4:0] RI_BGEZ = 5'h01;

    typedef struct packed {
        fmt_e        fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    function automatic logic [31:0] pack_word(input instr_fields_t f);
        logic [31:0] w;
        case (f.fmt)
            FMT_R:   w = {OP_SPECIAL, f.rs, f.rt, f.rd, f.sh, f.op};
            FMT_I:   w = {f.op, f.rs, f.rt, f.imm};
            FMT_J:   w = {f.op, f.target};
            default: w = {OP_REGIMM, f.rs, f.op[4:0], f.imm};
        endcase
        return w;
    endfunction

    // REGIMM legality looks only at the branch-code bits that are actually packed.
    function automatic logic op_legal(input fmt_e fmt, input logic [5:0] op);
        logic ok;
        case (fmt)
            FMT_I: ok = op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_ADDIU, OP_SLTI,
                                   OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SPECIAL2,
                                   OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW};
            FMT_J:      ok = op inside {OP_J, OP_JAL};
            FMT_REGIMM: ok = op[4:0] inside {RI_BLTZ, RI_BGEZ};
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for packed instruction words; head is a registered-storage read.
// Latency: one cycle push-to-head. Backpressure: a full FIFO refuses push even on a same-cycle pop.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (occ == CW'(DEPTH));
    assign empty   = (occ == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into words and streams them to instruction memory via a 4-deep FIFO.
// Latency: >=1 cycle input to write. Backpressure: w_mem_ready stalls the FIFO head; w_in_ready drops when full. Option: ENCODER_CHECK_EN.
module instr_encoder
    import isa_codes::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        w_start,
    input  logic [31:0] w_base_addr_32,
    input  logic        w_end,
    input  logic        w_in_valid,
    output logic        w_in_ready,
    input  logic [1:0]  w_fmt_2,
    input  logic [5:0]  w_op_type_6,
    input  logic [4:0]  w_rs_addr_5,
    input  logic [4:0]  w_rt_addr_5,
    input  logic [4:0]  w_rd_addr_5,
    input  logic [4:0]  w_sh_amt_5,
    input  logic [15:0] w_imm_val_16,
    input  logic [25:0] w_target_26,
    output logic [31:0] w_mem_addr_32,
    output logic [31:0] w_mem_data_32,
    output logic        w_mem_we,
    input  logic        w_mem_ready,
    output logic        w_busy,
    output logic        w_done,
    output logic [15:0] w_count_16,
    output logic        w_err
);
    enc_state_e    state;
    enc_state_e    state_nxt;
    logic          end_flag;
    logic [31:0]   addr;
    logic [15:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          start_acc;
    logic          push;
    logic          pop;
    logic          word_ok;
    logic [31:0]   word;
    instr_fields_t fields;

    assign fields = '{fmt: fmt_e'(w_fmt_2), op: w_op_type_6, rs: w_rs_addr_5,
                      rt: w_rt_addr_5, rd: w_rd_addr_5, sh: w_sh_amt_5,
                      imm: w_imm_val_16, target: w_target_26};

    assign start_acc  = (state == ST_IDLE) && w_start;
    assign w_in_ready = (state == ST_RUN) && !fifo_full && !end_flag;
    assign push       = w_in_valid && w_in_ready;
    assign w_mem_we   = (state == ST_RUN) && !fifo_empty;
    assign pop        = w_mem_we && w_mem_ready;

`ifdef ENCODER_CHECK_EN
    logic err;

    assign word_ok = op_legal(fields.fmt, fields.op);
    assign w_err   = err;

    // Sticky across the session; only a new accepted start clears it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (start_acc) begin
            err <= 1'b0;
        end else if (push && !word_ok) begin
            err <= 1'b1;
        end
    end
`else
    assign word_ok = 1'b1;
    assign w_err   = 1'b0;
`endif

    assign word = word_ok ? pack_word(fields) : 32'h0000_0000;

    instr_fifo #(.DEPTH(4), .WIDTH(32)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .head      (w_mem_data_32),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (w_start) state_nxt = ST_RUN;
            ST_RUN:  if (end_flag && fifo_empty) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            addr     <= 32'h0000_0000;
            count    <= 16'h0000;
            end_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                addr     <= w_base_addr_32;
                count    <= 16'h0000;
                end_flag <= 1'b0;
            end else begin
                if (pop) begin
                    addr <= addr + 32'd4;
                    if (count != 16'hFFFF) begin
                        count <= count + 16'd1;
                    end
                end
                if ((state == ST_RUN) && w_end) begin
                    end_flag <= 1'b1;
                end
            end
        end
    end

    assign w_mem_addr_32 = addr;
    assign w_count_16    = count;
    assign w_busy        = (state != ST_IDLE);
    assign w_done        = (state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, stall/wrap/end/reset sequences, random traffic.
module tb_instr_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        w_start = 1'b0;
    logic [31:0] w_base_addr_32 = '0;
    logic        w_end = 1'b0;
    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [1:0]  w_fmt_2 = '0;
    logic [5:0]  w_op_type_6 = '0;
    logic [4:0]  w_rs_addr_5 = '0;
    logic [4:0]  w_rt_addr_5 = '0;
    logic [4:0]  w_rd_addr_5 = '0;
    logic [4:0]  w_sh_amt_5 = '0;
    logic [15:0] w_imm_val_16 = '0;
    logic [25:0] w_target_26 = '0;
    logic [31:0] w_mem_addr_32;
    logic [31:0] w_mem_data_32;
    logic        w_mem_we;
    logic        w_mem_ready;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_count_16;
    logic        w_err;

    logic ready_set = 1'b1;
    logic rnd_mode  = 1'b0;
    logic rnd_bit   = 1'b1;
    assign w_mem_ready = rnd_mode ? rnd_bit : ready_set;

    instr_encoder dut (
        .clock(clock), .reset(reset), .w_start(w_start), .w_base_addr_32(w_base_addr_32),
        .w_end(w_end), .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_fmt_2(w_fmt_2),
        .w_op_type_6(w_op_type_6), .w_rs_addr_5(w_rs_addr_5), .w_rt_addr_5(w_rt_addr_5),
        .w_rd_addr_5(w_rd_addr_5), .w_sh_amt_5(w_sh_amt_5), .w_imm_val_16(w_imm_val_16),
        .w_target_26(w_target_26), .w_mem_addr_32(w_mem_addr_32), .w_mem_data_32(w_mem_data_32),
        .w_mem_we(w_mem_we), .w_mem_ready(w_mem_ready), .w_busy(w_busy), .w_done(w_done),
        .w_count_16(w_count_16), .w_err(w_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) rnd_bit <= 1'($urandom_range(0, 1));

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    int unsigned total = 0;
    int unsigned passed = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] addr_exp = '0;
    logic [15:0] count_exp = '0;
    logic        err_exp = 1'b0;
    logic [31:0] last_data = '0;
    logic [31:0] last_addr = '0;
    int unsigned wr_seen = 0;

    int unsigned legal_i_ops[17] = '{4, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 28, 32, 35, 36, 40, 43};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s actual=%h required=%h", name, act, req);
        else passed++;
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s (no response within cycle budget)", name);
    endtask

    function automatic bit ref_legal(input vec_t v);
`ifdef ENCODER_CHECK_EN
        bit ok = 0;
        case (v.fmt)
            2'd0: ok = 1;
            2'd1: foreach (legal_i_ops[k]) if (int'(v.op) == legal_i_ops[k]) ok = 1;
            2'd2: ok = (v.op == 6'd2) || (v.op == 6'd3);
            default: ok = (int'(v.op) % 32) <= 1;
        endcase
        return ok;
`else
        return 1;
`endif
    endfunction

    function automatic logic [31:0] ref_word(input vec_t v);
        int unsigned w;
        if (!ref_legal(v)) return 32'h0;
        case (v.fmt)
            2'd0: w = (int'(v.rs) << 21) + (int'(v.rt) << 16) + (int'(v.rd) << 11)
                      + (int'(v.sh) << 6) + int'(v.op);
            2'd1: w = (int'(v.op) << 26) + (int'(v.rs) << 21) + (int'(v.rt) << 16) + int'(v.imm);
            2'd2: w = (int'(v.op) << 26) + int'(v.tgt);
            default: w = (1 << 26) + (int'(v.rs) << 21) + ((int'(v.op) % 32) << 16) + int'(v.imm);
        endcase
        return w;
    endfunction

    function automatic vec_t rand_vec(input bit r_only);
        vec_t v;
        v.fmt = r_only ? 2'd0 : 2'($urandom_range(0, 3));
        v.op  = 6'($urandom_range(0, 63));
        v.rs  = 5'($urandom_range(0, 31));
        v.rt  = 5'($urandom_range(0, 31));
        v.rd  = 5'($urandom_range(0, 31));
        v.sh  = 5'($urandom_range(0, 31));
        v.imm = 16'($urandom_range(0, 65535));
        v.tgt = 26'($urandom());
        v.exp = '0;
        return v;
    endfunction

    // Write monitor: every completed write must match the model's next word and address.
    always @(negedge clock) begin
        if (reset && w_mem_we && w_mem_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write actual=%h@%h required=none", w_mem_data_32, w_mem_addr_32);
            end else begin
                check("wr_data", w_mem_data_32, exp_q.pop_front());
                check("wr_addr", w_mem_addr_32, addr_exp);
            end
            last_data = w_mem_data_32;
            last_addr = w_mem_addr_32;
            addr_log.push_back(w_mem_addr_32);
            addr_exp  = addr_exp + 32'd4;
            if (count_exp != 16'hFFFF) count_exp = count_exp + 16'd1;
            wr_seen++;
        end
    end

    task automatic drive(input vec_t v);
        w_fmt_2 = v.fmt; w_op_type_6 = v.op; w_rs_addr_5 = v.rs; w_rt_addr_5 = v.rt;
        w_rd_addr_5 = v.rd; w_sh_amt_5 = v.sh; w_imm_val_16 = v.imm; w_target_26 = v.tgt;
    endtask

    task automatic accept_model(input vec_t v);
        exp_q.push_back(ref_word(v));
        if (!ref_legal(v)) err_exp = 1'b1;
    endtask

    task automatic start(input logic [31:0] base, input logic with_end);
        w_start = 1'b1; w_base_addr_32 = base; w_end = with_end;
        @(posedge clock);
        addr_exp = base; count_exp = '0; err_exp = 1'b0; addr_log.delete();
        #1 w_start = 1'b0; w_end = 1'b0;
    endtask

    task automatic send(input vec_t v);
        bit got = 0;
        drive(v);
        w_in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (w_in_ready) begin
                got = 1;
                accept_model(v);
            end
        end
        @(posedge clock); #1 w_in_valid = 1'b0;
        if (!got) fail_now("send_accept");
    endtask

    // Leaves the caller at a negedge after the last write has taken effect.
    task automatic wait_drain();
        bit empty = 0;
        for (int i = 0; i < 300 && !empty; i++) begin
            @(negedge clock); #2;
            empty = (exp_q.size() == 0);
        end
        if (!empty) fail_now("drain");
        @(negedge clock);
    endtask

    task automatic wait_done();
        int ndone = 0;
        bit idle_seen = 0;
        for (int i = 0; i < 300 && !idle_seen; i++) begin
            @(negedge clock);
            if (w_done) ndone++;
            else if (ndone > 0) begin
                check("idle_after_done", 32'(w_busy), 32'd0);
                idle_seen = 1;
            end
        end
        check("done_pulses", ndone, 1);
        @(posedge clock); #1;
    endtask

    task automatic pulse_end();
        w_end = 1'b1;
        @(posedge clock); #1 w_end = 1'b0;
    endtask

    vec_t tbl[4];
    vec_t sv[5];
    int   acc;
    bit   have;
    logic [31:0] sd, sa;
    int unsigned w0, nbad;

    initial begin
        tbl[0] = '{fmt: 2'd0, op: 6'h21, rs: 5'd1, rt: 5'd2, rd: 5'd3, sh: 5'd0, imm: 16'h0, tgt: 26'h0, exp: 32'h00221821};
        tbl[1] = '{fmt: 2'd1, op: 6'h09, rs: 5'd0, rt: 5'd8, rd: 5'd0, sh: 5'd0, imm: 16'h0005, tgt: 26'h0, exp: 32'h24080005};
        tbl[2] = '{fmt: 2'd2, op: 6'h02, rs: 5'd0, rt: 5'd0, rd: 5'd0, sh: 5'd0, imm: 16'h0, tgt: 26'h0100000, exp: 32'h08100000};
        tbl[3] = '{fmt: 2'd3, op: 6'h01, rs: 5'd4, rt: 5'd0, rd: 5'd0, sh: 5'd0, imm: 16'hFFFE, tgt: 26'h0, exp: 32'h0481FFFE};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_we", 32'(w_mem_we), 0);
        check("rst_in_ready", 32'(w_in_ready), 0);
        check("rst_done", 32'(w_done), 0);
        check("rst_busy", 32'(w_busy), 0);
        check("rst_count", 32'(w_count_16), 0);
        check("rst_err", 32'(w_err), 0);
        check("rst_addr", w_mem_addr_32, 0);
        @(posedge clock); #1 reset = 1'b1;

        // w_end in IDLE and together with start must both be ignored
        pulse_end();
        start(32'h0040_0000, 1'b1);
        check("busy_in_run", 32'(w_busy), 1);
        for (int i = 0; i < 4; i++) begin
            send(tbl[i]);
            wait_drain();
            check("tbl_data", last_data, tbl[i].exp);
            check("tbl_addr", last_addr, 32'h0040_0000 + 32'(4 * i));
            check("tbl_count", 32'(w_count_16), 32'(i + 1));
            @(posedge clock); #1;
        end
        pulse_end();
        wait_done();

        // Stall: memory not ready, 5 words offered
        ready_set = 1'b0;
        start(32'h0000_1000, 1'b0);
        for (int i = 0; i < 5; i++) sv[i] = rand_vec(1);
        acc = 0; have = 0;
        drive(sv[0]); w_in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (acc == 4) check("full_in_ready", 32'(w_in_ready), 0);
            if (w_mem_we) begin
                if (!have) begin sd = w_mem_data_32; sa = w_mem_addr_32; have = 1; end
                else begin
                    check("stall_data_stable", w_mem_data_32, sd);
                    check("stall_addr_stable", w_mem_addr_32, sa);
                end
            end
            if (w_in_ready && acc < 5) begin accept_model(sv[acc]); acc++; end
            @(posedge clock); #1;
            if (acc < 5) drive(sv[acc]);
        end
        check("stall_accepted", acc, 4);
        check("stall_head", sd, ref_word(sv[0]));
        ready_set = 1'b1;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            @(negedge clock);
            if (w_in_ready) begin accept_model(sv[acc]); acc++; end
            @(posedge clock); #1;
        end
        w_in_valid = 1'b0;
        check("stall_fifth", acc, 5);
        wait_drain();
        check("stall_count", 32'(w_count_16), 5);
        @(posedge clock); #1;
        pulse_end();
        wait_done();

        // Address wrap
        start(32'hFFFF_FFFC, 1'b0);
        send(rand_vec(1));
        send(rand_vec(1));
        wait_drain();
        check("wrap_n", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("wrap_addr0", addr_log[0], 32'hFFFF_FFFC);
            check("wrap_addr1", addr_log[1], 32'h0000_0000);
        end
        @(posedge clock); #1;
        pulse_end();
        wait_done();

        // End with 3 buffered words
        ready_set = 1'b0;
        start(32'h0000_2000, 1'b0);
        for (int i = 0; i < 3; i++) send(rand_vec(0));
        w0 = wr_seen;
        pulse_end();
        @(negedge clock);
        check("end_in_ready", 32'(w_in_ready), 0);
        check("end_still_busy", 32'(w_busy), 1);
        @(posedge clock); #1 ready_set = 1'b1;
        wait_done();
        check("end_writes", wr_seen - w0, 3);
        check("end_queue_empty", exp_q.size(), 0);

        // Illegal opcode handling
        start(32'h0000_3000, 1'b0);
        send('{fmt: 2'd1, op: 6'h3F, rs: 5'd0, rt: 5'd0, rd: 5'd0, sh: 5'd0, imm: 16'h1234, tgt: 26'h0, exp: 32'h0});
        wait_drain();
`ifdef ENCODER_CHECK_EN
        check("illegal_word", last_data, 32'h0000_0000);
        check("illegal_err", 32'(w_err), 1);
        @(posedge clock); #1;
        send(tbl[1]);
        wait_drain();
        check("err_sticky", 32'(w_err), 1);
`else
        check("unchecked_word", last_data, 32'hFC00_1234);
        check("unchecked_err", 32'(w_err), 0);
`endif
        @(posedge clock); #1;
        pulse_end();
        wait_done();
        start(32'h0000_4000, 1'b0);
        @(negedge clock);
        check("err_cleared_by_start", 32'(w_err), 0);
        @(posedge clock); #1;
        pulse_end();
        wait_done();

        // Random traffic against the model
        start($urandom(), 1'b0);
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(rand_vec(0));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
        wait_drain();
        check("rnd_count", 32'(w_count_16), 32'(count_exp));
        check("rnd_err", 32'(w_err), 32'(err_exp));
        @(posedge clock); #1;
        rnd_mode = 1'b0;
        pulse_end();
        wait_done();

        // Reset mid-session discards buffered words
        ready_set = 1'b0;
        start(32'h0000_5000, 1'b0);
        send(rand_vec(1));
        send(rand_vec(1));
        reset = 1'b0;
        @(posedge clock);
        exp_q.delete();
        #1;
        @(posedge clock); #1 reset = 1'b1; ready_set = 1'b1;
        nbad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (w_mem_we || w_done || w_busy) nbad++;
        end
        check("post_reset_quiet", nbad, 0);
        check("post_reset_count", 32'(w_count_16), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
